// File: rtl/spi_wr_master.sv
// spi_wr_master: serialises one {addr, data} register write per request into a
// cs_n-framed SPI transaction that a spi_slave on the same clk captures.
//
// Ports:
//   clk        system clock, shared with the slave
//   reset      synchronous active-high reset
//   req_valid  write request present
//   req_ready  request accepted this cycle when high with req_valid (IDLE only)
//   req_addr   4-bit register address, latched on handshake
//   req_data   8-bit write data, latched on handshake
//   sclk       SPI clock, idles low
//   cs_n       SPI chip select, active low
//   mosi       serial data, MSB first
//   busy       high whenever not IDLE
//   done       one-cycle pulse on the first GAP cycle of a completed frame
module spi_wr_master #(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned IDLE_GAP = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [3:0] req_addr,
   input  logic [7:0] req_data,
   output logic       sclk,
   output logic       cs_n,
   output logic       mosi,
   output logic       busy,
   output logic       done
);

   localparam int unsigned DIV_W   = $clog2(CLK_DIV) + 1;
   localparam int unsigned GAP_W   = $clog2(IDLE_GAP) + 1;
   localparam int unsigned FRAME_W = 14;
   localparam int unsigned BIT_W   = 4;

   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IDLE_GAP - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;
   localparam logic [1:0] ST_GAP   = 2'd3;

   // Reject illegal timing parameters at elaboration
   if (CLK_DIV < 4) begin : g_bad_clk_div
      $error("spi_wr_master: CLK_DIV must be >= 4");
   end
   if (IDLE_GAP < 1) begin : g_bad_idle_gap
      $error("spi_wr_master: IDLE_GAP must be >= 1");
   end

   logic [1:0]         state,   state_d;
   logic [DIV_W-1:0]   div_cnt, div_cnt_d;
   logic [BIT_W-1:0]   bit_cnt, bit_cnt_d;
   logic [GAP_W-1:0]   gap_cnt, gap_cnt_d;
   logic [FRAME_W-1:0] frame,   frame_d;
   logic               sclk_d, cs_n_d, mosi_d, done_d;
   logic [BIT_W-1:0]   nxt_bit;

   assign req_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);

   // State and registered-output update
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         div_cnt <= '0;
         bit_cnt <= '0;
         gap_cnt <= '0;
         frame   <= '0;
         sclk    <= 1'b0;
         cs_n    <= 1'b1;
         mosi    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_d;
         div_cnt <= div_cnt_d;
         bit_cnt <= bit_cnt_d;
         gap_cnt <= gap_cnt_d;
         frame   <= frame_d;
         sclk    <= sclk_d;
         cs_n    <= cs_n_d;
         mosi    <= mosi_d;
         done    <= done_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d   = state;
      div_cnt_d = div_cnt;
      bit_cnt_d = bit_cnt;
      gap_cnt_d = gap_cnt;
      frame_d   = frame;
      sclk_d    = sclk;
      cs_n_d    = cs_n;
      mosi_d    = mosi;
      done_d    = 1'b0;
      nxt_bit   = bit_cnt + BIT_W'(1);

      case (state)
         ST_IDLE: begin
            cs_n_d = 1'b1;
            sclk_d = 1'b0;
            mosi_d = 1'b0;
            if (req_valid) begin
               // Dummy leading bit wakes the slave, trailing commit bit fires its write
               frame_d   = {1'b0, req_addr, req_data, 1'b0};
               state_d   = ST_SHIFT;
               div_cnt_d = '0;
               bit_cnt_d = '0;
               cs_n_d    = 1'b0;
               mosi_d    = frame_d[FRAME_W-1];
            end
         end

         ST_SHIFT: begin
            cs_n_d = 1'b0;
            if (div_cnt == DIV_LAST) begin
               div_cnt_d = '0;
               if (!sclk) begin
                  sclk_d = 1'b1;
               end else if (bit_cnt == LAST_BIT) begin
                  sclk_d  = 1'b0;
                  mosi_d  = 1'b0;
                  state_d = ST_HOLD;
               end else begin
                  // mosi changes only at the start of a low half
                  sclk_d    = 1'b0;
                  bit_cnt_d = nxt_bit;
                  mosi_d    = frame[LAST_BIT - nxt_bit];
               end
            end else begin
               div_cnt_d = div_cnt + DIV_W'(1);
            end
         end

         ST_HOLD: begin
            // Keep cs_n low while the slave's registered edge detect acts on the commit bit
            cs_n_d = 1'b0;
            sclk_d = 1'b0;
            mosi_d = 1'b0;
            if (div_cnt == DIV_LAST) begin
               div_cnt_d = '0;
               gap_cnt_d = '0;
               cs_n_d    = 1'b1;
               done_d    = 1'b1;
               state_d   = ST_GAP;
            end else begin
               div_cnt_d = div_cnt + DIV_W'(1);
            end
         end

         ST_GAP: begin
            cs_n_d = 1'b1;
            sclk_d = 1'b0;
            mosi_d = 1'b0;
            if (gap_cnt == GAP_LAST) begin
               gap_cnt_d = '0;
               state_d   = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt + GAP_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_spi_wr_master.sv
// Self-checking bench for spi_wr_master: directed scenarios plus random writes,
// with a frame-level monitor acting as the receiving slave.
module tb_spi_wr_master;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_valid;
   logic [3:0] req_addr;
   logic [7:0] req_data;
   logic       sel;

   logic rdy4, sclk4, cs4, mosi4, busy4, done4;
   logic rdy8, sclk8, cs8, mosi8, busy8, done8;
   logic o_ready, o_sclk, o_cs_n, o_mosi, o_busy, o_done;

   always #5 clk = ~clk;

   spi_wr_master #(.CLK_DIV(4), .IDLE_GAP(4)) u_dut4 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy4),
      .req_addr(req_addr), .req_data(req_data), .sclk(sclk4), .cs_n(cs4),
      .mosi(mosi4), .busy(busy4), .done(done4));

   spi_wr_master #(.CLK_DIV(8), .IDLE_GAP(1)) u_dut8 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy8),
      .req_addr(req_addr), .req_data(req_data), .sclk(sclk8), .cs_n(cs8),
      .mosi(mosi8), .busy(busy8), .done(done8));

   assign o_ready = sel ? rdy8  : rdy4;
   assign o_sclk  = sel ? sclk8 : sclk4;
   assign o_cs_n  = sel ? cs8   : cs4;
   assign o_mosi  = sel ? mosi8 : mosi4;
   assign o_busy  = sel ? busy8 : busy4;
   assign o_done  = sel ? done8 : done4;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: expected writes in acceptance order, and frame timing
   logic [11:0] exp_q[$];
   int          m_div = 4;
   int          m_gap = 4;

   // Monitor state (acts as the slave; samples on the falling edge)
   int          cyc = 0;
   int          low_len, run_len, hi_len = 1000, rises = 0;
   int          writes_seen = 0, done_cnt = 0;
   logic [13:0] bits, last_bits;
   logic        in_frame = 1'b0;
   logic        p_cs = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0;
   logic [11:0] e;

   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         in_frame = 1'b0;
         hi_len   = 1000;
      end else begin
         if (o_done) done_cnt++;
         if (o_cs_n) begin
            chk("mosi_idle", o_mosi, 0);
            chk("sclk_idle", o_sclk, 0);
            if (!p_cs) begin
               hi_len = 1;
               if (in_frame) begin
                  chk("cs_low_len", low_len, 29 * m_div);
                  chk("hold_len", run_len, m_div);
                  chk("rise_count", rises, 14);
                  chk("done_at_end", o_done, 1);
                  last_bits = bits;
                  if (exp_q.size() == 0) begin
                     chk("unexpected_frame", 0, 1);
                  end else begin
                     e = exp_q.pop_front();
                     chk("frame_bits", bits, {1'b0, e, 1'b0});
                  end
                  writes_seen++;
               end
               in_frame = 1'b0;
            end else begin
               hi_len++;
               chk("done_spurious", o_done, 0);
            end
         end else begin
            if (p_cs) begin
               chk("gap_len", hi_len >= m_gap, 1);
               in_frame = 1'b1;
               low_len  = 0;
               run_len  = 0;
               rises    = 0;
               bits     = '0;
            end
            low_len++;
            if (o_sclk != p_sclk) begin
               chk("phase_len", run_len, m_div);
               run_len = 0;
               if (o_sclk) begin
                  bits = {bits[12:0], o_mosi};
                  rises++;
               end
            end else if (o_sclk && p_sclk) begin
               chk("mosi_stable", o_mosi, p_mosi);
            end
            run_len++;
            chk("done_in_frame", o_done, 0);
         end
      end
      p_cs   = o_cs_n;
      p_sclk = o_sclk;
      p_mosi = o_mosi;
   end

   // Stimulus is applied 1 time unit after the falling edge
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic do_req(input logic [3:0] a, input logic [7:0] d, output int hs);
      int n;
      req_valid = 1'b1;
      req_addr  = a;
      req_data  = d;
      n = 0;
      while (!o_ready && n < 2000) begin
         step();
         n++;
      end
      chk("hs_timeout", o_ready, 1);
      hs = cyc;
      exp_q.push_back({a, d});
      step();
      chk("ready_drop", o_ready, 0);
      chk("cs_fall", o_cs_n, 0);
      chk("busy_set", o_busy, 1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (o_busy && n < 3000) begin
         step();
         n++;
      end
      chk("idle_timeout", o_busy, 0);
      step();
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_cs_n"}, o_cs_n, 1);
      chk({tag, "_sclk"}, o_sclk, 0);
      chk({tag, "_mosi"}, o_mosi, 0);
      chk({tag, "_done"}, o_done, 0);
      chk({tag, "_busy"}, o_busy, 0);
      chk({tag, "_ready"}, o_ready, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t1, t2, n, w0, d0;
      logic [13:0] exp_bits;

      reset = 1'b1; sel = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0;
      step(); step();
      check_idle("reset");
      reset = 1'b0;

      // Post-reset idle for 50 cycles
      for (int i = 0; i < 50; i++) begin
         step();
         check_idle("idle50");
      end

      // Single write A / 5C
      d0 = done_cnt;
      do_req(4'hA, 8'h5C, t1);
      req_valid = 1'b0;
      wait_idle();
      chk("t1_writes", writes_seen, 1);
      chk("t1_done_once", done_cnt - d0, 1);
      exp_bits = 14'b01010010111000;
      chk("t1_bits", last_bits, exp_bits);

      // Back-to-back with req_valid held
      do_req(4'h3, 8'hFF, t1);
      do_req(4'hF, 8'h01, t2);
      req_valid = 1'b0;
      chk("b2b_interval", t2 - t1, 1 + 29 * m_div + m_gap);
      wait_idle();
      chk("b2b_writes", writes_seen, 3);

      // Reset during bit 8
      w0 = writes_seen;
      d0 = done_cnt;
      do_req(4'h7, 8'h99, t1);
      req_valid = 1'b0;
      for (int i = 0; i < 16 * m_div + 1; i++) step();
      chk("rst_at_bit8", rises, 8);
      reset = 1'b1;
      step();
      check_idle("midrst");
      reset = 1'b0;
      void'(exp_q.pop_front());
      for (int i = 0; i < 20; i++) step();
      chk("rst_no_write", writes_seen, w0);
      chk("rst_no_done", done_cnt, d0);
      do_req(4'h2, 8'h33, t1);
      req_valid = 1'b0;
      wait_idle();
      chk("rst_recover", writes_seen, w0 + 1);

      // Inputs scrambled every cycle after the handshake
      do_req(4'h6, 8'hA5, t1);
      req_valid = 1'b0;
      n = 0;
      while (!o_ready && n < 1000) begin
         req_addr = 4'($urandom);
         req_data = 8'($urandom);
         n++;
         step();
      end
      chk("stab_ready_low", n, 29 * m_div + m_gap);
      wait_idle();
      chk("stab_writes", writes_seen, w0 + 2);

      // Random writes with random spacing
      w0 = writes_seen;
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < int'($urandom_range(0, 5)); j++) step();
         do_req(4'($urandom), 8'($urandom), t1);
         req_valid = 1'b0;
      end
      wait_idle();
      chk("rand_writes", writes_seen, w0 + 8);
      chk("rand_q_empty", exp_q.size(), 0);

      // CLK_DIV=8, IDLE_GAP=1 instance
      reset = 1'b1; sel = 1'b1; m_div = 8; m_gap = 1;
      step(); step();
      check_idle("reset8");
      reset = 1'b0;
      step();
      w0 = writes_seen;
      do_req(4'h0, 8'h00, t1);
      do_req(4'hF, 8'hFF, t2);
      req_valid = 1'b0;
      chk("div8_interval", t2 - t1, 234);
      wait_idle();
      chk("div8_writes", writes_seen, w0 + 2);
      chk("final_q_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
